// File: rtl/scan_demux_if.sv
// Display scan bus seen by scan_demux: the scanned digit select and nibble
// coming in, the re-assembled bytes and status pulses going out.
interface scan_demux_if;
    logic [3:0] Enable;
    logic [3:0] disp;
    logic [7:0] out1;
    logic [7:0] out2;
    logic       frame_valid;
    logic       seq_err;
    logic       locked;

    // Side that drives the display bus and watches the monitor results
    modport master (
        output Enable,
        output disp,
        input  out1,
        input  out2,
        input  frame_valid,
        input  seq_err,
        input  locked
    );

    // The monitor itself
    modport slave (
        input  Enable,
        input  disp,
        output out1,
        output out2,
        output frame_valid,
        output seq_err,
        output locked
    );
endinterface

// File: rtl/scan_demux.sv
// scan_demux: receive side of the 4-digit multiplexed display bus.
// Registers the scanned digit select and nibble, filters short glitches,
// follows the idx0..idx3 scan order and re-assembles the two displayed bytes.
// Optional feature macro: SCAN_LIVE_EN -- when defined, out1/out2 nibbles
// follow every accepted digit instead of changing only at frame commit.
module scan_demux #(
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int unsigned MIN_HOLD   = 1
) (
    input  logic         clk,
    input  logic         rst,
    scan_demux_if.slave  bus
);

    localparam logic [3:0] SEL_BLANK = 4'b1111;
    localparam logic [3:0] HOLD_MAX  = 4'(MIN_HOLD);
    localparam logic [4:0] HOLD_REQ  = 5'(MIN_HOLD);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        K_DIGIT   = 2'd0,
        K_BLANK   = 2'd1,
        K_ILLEGAL = 2'd2
    } kind_t;

    // Bring the select into active-low form so decode is polarity independent.
    function automatic logic [3:0] norm_sel(input logic [3:0] raw);
        return ACTIVE_LOW ? raw : ~raw;
    endfunction

    // Hold counter increment, saturating at MIN_HOLD.
    function automatic logic [3:0] hold_inc(input logic [3:0] cnt);
        return (cnt >= HOLD_MAX) ? HOLD_MAX : cnt + 4'd1;
    endfunction

    // Classify a normalised select pattern.
    function automatic kind_t decode_kind(input logic [3:0] sel);
        case (sel)
            4'b0111, 4'b1011, 4'b1101, 4'b1110: return K_DIGIT;
            4'b1111:                            return K_BLANK;
            default:                            return K_ILLEGAL;
        endcase
    endfunction

    // Digit index of a legal one-cold pattern (don't care otherwise).
    function automatic logic [1:0] decode_idx(input logic [3:0] sel);
        case (sel)
            4'b0111: return 2'd0;
            4'b1011: return 2'd1;
            4'b1101: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    logic [3:0] sel_in;
    logic [3:0] sel_p1;
    logic [3:0] nib_p1;
    logic [3:0] hold_p1;

    logic       qual;
    kind_t      kind;
    logic [1:0] idx;

    state_t     state, state_nxt;
    logic [1:0] exp_idx, exp_nxt;
    logic [1:0] last_idx, last_nxt;
    logic [15:0] shadow, shadow_nxt;
    logic [7:0] out1_q, out1_nxt;
    logic [7:0] out2_q, out2_nxt;
    logic       fv_q, fv_nxt;
    logic       se_q, se_nxt;
    logic       locked_q;
    logic       start;
    logic       write;

    assign sel_in = norm_sel(bus.Enable);

    // ---- stage 1: input sampling and hold filter ----
    // Register the bus each edge and count how long the sample has been stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_p1  <= SEL_BLANK;
            nib_p1  <= 4'h0;
            hold_p1 <= 4'd0;
        end else begin
            sel_p1 <= sel_in;
            nib_p1 <= bus.disp;
            if (sel_in != sel_p1 || bus.disp != nib_p1) begin
                hold_p1 <= 4'd0;
            end else begin
                hold_p1 <= hold_inc(hold_p1);
            end
        end
    end

    assign qual = ({1'b0, hold_p1} + 5'd1) >= HOLD_REQ;
    assign kind = decode_kind(sel_p1);
    assign idx  = decode_idx(sel_p1);

    // ---- stage 2: sequence tracking and byte assembly ----
    // Next-state logic: follow the scan order, capture nibbles, flag errors.
    // An out-of-order idx0 reports the error and immediately opens a new frame.
    always_comb begin
        state_nxt  = state;
        exp_nxt    = exp_idx;
        last_nxt   = last_idx;
        shadow_nxt = shadow;
        out1_nxt   = out1_q;
        out2_nxt   = out2_q;
        fv_nxt     = 1'b0;
        se_nxt     = 1'b0;
        start      = 1'b0;
        write      = 1'b0;

        if (qual) begin
            case (state)
                HUNT: begin
                    if (kind == K_DIGIT && idx == 2'd0) begin
                        start = 1'b1;
                    end
                end
                LOCK: begin
                    if (kind == K_BLANK) begin
                        start = 1'b0;
                    end else if (kind == K_DIGIT && idx == exp_idx) begin
                        write    = 1'b1;
                        last_nxt = idx;
                        exp_nxt  = idx + 2'd1;
                        fv_nxt   = (exp_idx == 2'd3);
                    end else if (kind == K_DIGIT && idx == last_idx) begin
                        write = 1'b1;
                    end else begin
                        se_nxt    = 1'b1;
                        state_nxt = HUNT;
                        start     = (kind == K_DIGIT && idx == 2'd0);
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end

        if (start) begin
            write     = 1'b1;
            state_nxt = LOCK;
            last_nxt  = 2'd0;
            exp_nxt   = 2'd1;
        end

        if (write) begin
            case (idx)
                2'd0:    shadow_nxt[15:12] = nib_p1;
                2'd1:    shadow_nxt[11:8]  = nib_p1;
                2'd2:    shadow_nxt[7:4]   = nib_p1;
                default: shadow_nxt[3:0]   = nib_p1;
            endcase
        end

`ifdef SCAN_LIVE_EN
        if (write) begin
            case (idx)
                2'd0:    out1_nxt[7:4] = nib_p1;
                2'd1:    out1_nxt[3:0] = nib_p1;
                2'd2:    out2_nxt[7:4] = nib_p1;
                default: out2_nxt[3:0] = nib_p1;
            endcase
        end
`else
        if (fv_nxt) begin
            out1_nxt = shadow[15:8];
            out2_nxt = {shadow[7:4], nib_p1};
        end
`endif
    end

    // Stage 2 register: FSM state, sequence pointers, shadow and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            exp_idx  <= 2'd0;
            last_idx <= 2'd0;
            shadow   <= 16'h0000;
            out1_q   <= 8'h00;
            out2_q   <= 8'h00;
            fv_q     <= 1'b0;
            se_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            exp_idx  <= exp_nxt;
            last_idx <= last_nxt;
            shadow   <= shadow_nxt;
            out1_q   <= out1_nxt;
            out2_q   <= out2_nxt;
            fv_q     <= fv_nxt;
            se_q     <= se_nxt;
            locked_q <= (state_nxt == LOCK);
        end
    end

    assign bus.out1        = out1_q;
    assign bus.out2        = out2_q;
    assign bus.frame_valid = fv_q;
    assign bus.seq_err     = se_q;
    assign bus.locked      = locked_q;

endmodule

// File: tb/tb_scan_demux.sv
// Directed bench for scan_demux: one instance with MIN_HOLD=1 and one with
// MIN_HOLD=3 watching the same bus stream.
module tb_scan_demux;

    logic clk;
    logic rst;

    scan_demux_if bus ();
    scan_demux_if bus_h ();

    assign bus_h.Enable = bus.Enable;
    assign bus_h.disp   = bus.disp;

    scan_demux #(.ACTIVE_LOW(1'b1), .MIN_HOLD(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    scan_demux #(.ACTIVE_LOW(1'b1), .MIN_HOLD(3)) dut_h3 (
        .clk (clk),
        .rst (rst),
        .bus (bus_h.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int fv_cnt  = 0;
    int se_cnt  = 0;
    int both_cnt = 0;
    int h_fv_cnt = 0;
    int h_se_cnt = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Present one bus sample, wait one edge, then tally the pulses that edge produced.
    task automatic drive(input logic [3:0] e, input logic [3:0] d);
        bus.Enable = e;
        bus.disp   = d;
        @(posedge clk);
        #1;
        fv_cnt   += int'(bus.frame_valid);
        se_cnt   += int'(bus.seq_err);
        both_cnt += int'(bus.frame_valid & bus.seq_err);
        h_fv_cnt += int'(bus_h.frame_valid);
        h_se_cnt += int'(bus_h.seq_err);
    endtask

    task automatic drive_n(input logic [3:0] e, input logic [3:0] d, input int n);
        for (int i = 0; i < n; i++) drive(e, d);
    endtask

    task automatic do_reset();
        bus.Enable = 4'b1111;
        bus.disp   = 4'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.Enable = 4'b1111;
        bus.disp   = 4'h0;
        #2;
        chk("rst_out1", {8'h0, bus.out1}, 16'h0000);
        chk("rst_out2", {8'h0, bus.out2}, 16'h0000);
        chk("rst_fv", {15'h0, bus.frame_valid}, 16'h0000);
        chk("rst_se", {15'h0, bus.seq_err}, 16'h0000);
        chk("rst_locked", {15'h0, bus.locked}, 16'h0000);
        do_reset();

        // Test 1: basic frame A,5,C,3
        drive(4'b0111, 4'hA);
        drive(4'b1011, 4'h5);
`ifdef SCAN_LIVE_EN
        chk("t1_live_out1", {8'h0, bus.out1}, 16'h00A0);
`else
        chk("t1_buf_out1", {8'h0, bus.out1}, 16'h0000);
`endif
        chk("t1_locked_early", {15'h0, bus.locked}, 16'h0001);
        drive(4'b1101, 4'hC);
        drive(4'b1110, 4'h3);
        chk("t1_fv_not_yet", {15'h0, bus.frame_valid}, 16'h0000);
        drive(4'b1111, 4'h0);
        chk("t1_fv", {15'h0, bus.frame_valid}, 16'h0001);
        chk("t1_out1", {8'h0, bus.out1}, 16'h00A5);
        chk("t1_out2", {8'h0, bus.out2}, 16'h00C3);
        chk("t1_locked", {15'h0, bus.locked}, 16'h0001);
        chk("t1_se", {15'h0, bus.seq_err}, 16'h0000);
        drive(4'b1111, 4'h0);
        chk("t1_fv_pulse_end", {15'h0, bus.frame_valid}, 16'h0000);

        // Test 2: each digit held 4 clocks
        fv_cnt = 0;
        se_cnt = 0;
        drive_n(4'b0111, 4'h1, 4);
        drive_n(4'b1011, 4'h2, 4);
        drive_n(4'b1101, 4'h3, 4);
        drive_n(4'b1110, 4'h4, 4);
        drive_n(4'b1111, 4'h0, 2);
        chk("t2_fv_count", 16'(fv_cnt), 16'd1);
        chk("t2_se_count", 16'(se_cnt), 16'd0);
        chk("t2_out1", {8'h0, bus.out1}, 16'h0012);
        chk("t2_out2", {8'h0, bus.out2}, 16'h0034);

        // Test 3: skipped idx1, then a clean frame
        drive(4'b0111, 4'hF);
        drive(4'b1101, 4'hE);
        drive(4'b1111, 4'h0);
        chk("t3_se", {15'h0, bus.seq_err}, 16'h0001);
        chk("t3_locked", {15'h0, bus.locked}, 16'h0000);
`ifdef SCAN_LIVE_EN
        chk("t3_out1_hold", {8'h0, bus.out1}, 16'h00F2);
`else
        chk("t3_out1_hold", {8'h0, bus.out1}, 16'h0012);
`endif
        chk("t3_out2_hold", {8'h0, bus.out2}, 16'h0034);
        drive(4'b1111, 4'h0);
        chk("t3_se_pulse_end", {15'h0, bus.seq_err}, 16'h0000);
        fv_cnt = 0;
        drive(4'b0111, 4'h9);
        drive(4'b1011, 4'h8);
        drive(4'b1101, 4'h7);
        drive(4'b1110, 4'h6);
        drive(4'b1111, 4'h0);
        chk("t3_fv", {15'h0, bus.frame_valid}, 16'h0001);
        chk("t3_out1", {8'h0, bus.out1}, 16'h0098);
        chk("t3_out2", {8'h0, bus.out2}, 16'h0076);

        // Test 4: illegal pattern with interleaved blanks
        se_cnt = 0;
        drive(4'b0111, 4'h1);
        drive(4'b1111, 4'h0);
        drive(4'b1011, 4'h2);
        drive(4'b1111, 4'h0);
        chk("t4_blanks_no_err", 16'(se_cnt), 16'd0);
        drive(4'b0011, 4'h5);
        drive(4'b1111, 4'h0);
        chk("t4_se", {15'h0, bus.seq_err}, 16'h0001);
        chk("t4_locked", {15'h0, bus.locked}, 16'h0000);
        drive(4'b1011, 4'h3);
        drive_n(4'b1111, 4'h0, 2);
        chk("t4_se_count", 16'(se_cnt), 16'd1);
        chk("t4_hunt_locked", {15'h0, bus.locked}, 16'h0000);

        // Test 5: MIN_HOLD=3 glitch rejection
        do_reset();
        h_fv_cnt = 0;
        h_se_cnt = 0;
        drive_n(4'b0111, 4'hA, 3);
        drive(4'b1011, 4'h5);
        drive_n(4'b0111, 4'hA, 3);
        drive_n(4'b1011, 4'h6, 3);
        drive_n(4'b1101, 4'hC, 3);
        drive_n(4'b1110, 4'h3, 3);
        drive_n(4'b1111, 4'h0, 3);
        chk("t5_h3_se_count", 16'(h_se_cnt), 16'd0);
        chk("t5_h3_fv_count", 16'(h_fv_cnt), 16'd1);
        chk("t5_h3_out1", {8'h0, bus_h.out1}, 16'h00A6);
        chk("t5_h3_out2", {8'h0, bus_h.out2}, 16'h00C3);
        chk("t5_h3_locked", {15'h0, bus_h.locked}, 16'h0001);

        // Test 6: asynchronous reset mid-frame
        do_reset();
        drive(4'b0111, 4'h1);
        drive(4'b1011, 4'h2);
        drive(4'b1101, 4'h3);
        drive(4'b1111, 4'h0);
        chk("t6_locked_before", {15'h0, bus.locked}, 16'h0001);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_async_locked", {15'h0, bus.locked}, 16'h0000);
        chk("t6_async_out1", {8'h0, bus.out1}, 16'h0000);
        chk("t6_async_out2", {8'h0, bus.out2}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        fv_cnt = 0;
        se_cnt = 0;
        drive(4'b1110, 4'h4);
        drive_n(4'b1111, 4'h0, 2);
        chk("t6_fv_count", 16'(fv_cnt), 16'd0);
        chk("t6_se_count", 16'(se_cnt), 16'd0);
        chk("t6_locked_after", {15'h0, bus.locked}, 16'h0000);
        chk("t6_out1_after", {8'h0, bus.out1}, 16'h0000);

        chk("fv_se_exclusive", 16'(both_cnt), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
